// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit pipelined core.
package cpu_pkg;

    localparam int unsigned CPU_ADDR_W  = 16;
    localparam int unsigned CPU_DATA_W  = 16;
    localparam int unsigned CPU_TIMEOUT = 64;
    localparam int unsigned CPU_CNT_W   = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Loadable, clearable up-counter with a combinational terminal-count flag.
module mem_timeout_cnt #(
    parameter int unsigned CNT_W = 7,
    parameter int unsigned TERM  = 63
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             tc_c_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority over load, load over count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c_o = (cnt_q == CNT_W'(TERM));

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage controller: issues loads/stores over req/ack, stalls the pipe while
// a transaction is outstanding and presents results to the MEM/WB latch.
module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = CPU_ADDR_W,
    parameter int unsigned DATA_W  = CPU_DATA_W,
    parameter int unsigned TIMEOUT = CPU_TIMEOUT,
    parameter int unsigned CNT_W   = CPU_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              flush,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              WriteReg_in,
    input  logic [DATA_W-1:0] ALU_res_in,
    input  logic [DATA_W-1:0] store_data_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_n,
    output logic              WriteReg_out,
    output logic [DATA_W-1:0] ALU_res_out,
    output logic [DATA_W-1:0] data_mem_out,
    output logic              mem_err
);

    mem_state_t        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              wr_q, wr_d;
    logic              ld_q, ld_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic              live;
    logic              mem_op;
    logic              misalign;
    logic              tc;

    mem_timeout_cnt #(
        .CNT_W (CNT_W),
        .TERM  (TIMEOUT - 1)
    ) u_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (state_q != BUSY),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (state_q == BUSY),
        .tc_c_o     (tc)
    );

    // rst_n gates the live term so the combinational outputs are quiet in reset.
    assign live     = rst_n & valid_in & ~flush;
    assign mem_op   = live & (mem_read_in | mem_write_in);
    assign misalign = mem_op & ALU_res_in[0];

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        we_d         = we_q;
        err_d        = 1'b0;
        wr_d         = wr_q;
        ld_d         = ld_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        dout_d       = dout_q;
        alu_d        = alu_q;
        stall_n      = 1'b1;
        WriteReg_out = wr_q;
        ALU_res_out  = alu_q;

        case (state_q)
            IDLE: begin
                WriteReg_out = live & WriteReg_in & ~misalign;
                ALU_res_out  = rst_n ? ALU_res_in : '0;
                if (misalign) begin
                    err_d = 1'b1;
                end else if (mem_op) begin
                    stall_n = 1'b0;
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = mem_write_in;
                    ld_d    = ~mem_write_in;
                    addr_d  = ADDR_W'(ALU_res_in);
                    wdata_d = store_data_in;
                    wr_d    = WriteReg_in;
                    alu_d   = ALU_res_in;
                end
            end
            BUSY: begin
                stall_n = 1'b0;
                // Ack beats timeout when both land in the same cycle.
                if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (ld_q) begin
                        dout_d = mem_rdata;
                    end
                end else if (tc) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    wr_d    = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            ld_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            alu_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            ld_q    <= ld_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            alu_q   <= alu_d;
        end
    end

    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign data_mem_out = dout_q;
    assign mem_err      = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed and random instructions against a
// transaction-level model of the stage and a small word memory.
module tb_mem_access_stage;

    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        flush;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        WriteReg_in;
    logic [15:0] ALU_res_in;
    logic [15:0] store_data_in;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        stall_n;
    logic        WriteReg_out;
    logic [15:0] ALU_res_out;
    logic [15:0] data_mem_out;
    logic        mem_err;

    int          total;
    int          bad;
    logic [15:0] mem_model [0:255];
    logic [15:0] exp_dout;
    logic        exp_err_next;

    mem_access_stage #(
        .TIMEOUT (TO),
        .CNT_W   (7)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .flush         (flush),
        .mem_read_in   (mem_read_in),
        .mem_write_in  (mem_write_in),
        .WriteReg_in   (WriteReg_in),
        .ALU_res_in    (ALU_res_in),
        .store_data_in (store_data_in),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .stall_n       (stall_n),
        .WriteReg_out  (WriteReg_out),
        .ALU_res_out   (ALU_res_out),
        .data_mem_out  (data_mem_out),
        .mem_err       (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered and left 1 time unit after a rising edge. ack_after = BUSY cycle
    // that carries the ack (0 = never).
    task automatic run_instr(input logic v, input logic f, input logic rd, input logic wr,
                             input logic wreg, input logic [15:0] alu, input logic [15:0] sd,
                             input int ack_after, input bit flush_busy);
        logic memop, mis, tmo, done;
        int   exp_n, stall_cnt;
        memop = v & ~f & (rd | wr);
        mis   = memop & alu[0];
        tmo   = !(ack_after >= 1 && ack_after <= TO);
        exp_n = tmo ? TO : ack_after;

        chk("err_prev", mem_err, exp_err_next);
        chk("req_idle", mem_req, 0);
        chk("dout_prev", data_mem_out, exp_dout);
        valid_in = v; flush = f; mem_read_in = rd; mem_write_in = wr;
        WriteReg_in = wreg; ALU_res_in = alu; store_data_in = sd;
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
        #3;
        if (!memop || mis) begin
            chk("stall_idle", stall_n, 1);
            chk("wreg_idle", WriteReg_out, v & ~f & wreg & ~mis);
            chk("alu_idle", ALU_res_out, alu);
            exp_err_next = mis;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            return;
        end
        mem_ack = 1'b0;
        chk("stall_issue", stall_n, 0);
        stall_cnt = 1;
        done = 1'b0;
        for (int k = 1; k <= TO + 4 && !done; k++) begin
            @(posedge clk); #1;
            mem_ack = (k == ack_after);
            mem_rdata = mem_ack ? mem_model[alu[8:1]] : 16'($urandom);
            if (flush_busy) flush = 1'($urandom_range(0, 1));
            #3;
            if (!stall_n) begin
                stall_cnt++;
                chk("req_busy", mem_req, 1);
                chk("addr_busy", mem_addr, alu);
                chk("we_busy", mem_we, wr);
                if (wr) chk("wdata_busy", mem_wdata, sd);
                chk("err_busy", mem_err, 0);
            end else begin
                done = 1'b1;
                if (!tmo) begin
                    if (wr) mem_model[alu[8:1]] = sd;
                    else exp_dout = mem_model[alu[8:1]];
                end
                chk("req_done", mem_req, 0);
                chk("err_done", mem_err, tmo);
                chk("wreg_done", WriteReg_out, wreg & ~tmo);
                chk("alu_done", ALU_res_out, alu);
                chk("dout_done", data_mem_out, exp_dout);
            end
        end
        chk("done_seen", done, 1);
        chk("stall_cycles", stall_cnt, exp_n + 1);
        exp_err_next = 1'b0;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0;
        exp_dout = 16'h0; exp_err_next = 1'b0;
        rst_n = 1'b1; valid_in = 1'b0; flush = 1'b0; mem_read_in = 1'b0;
        mem_write_in = 1'b0; WriteReg_in = 1'b0; ALU_res_in = 16'h0;
        store_data_in = 16'h0; mem_ack = 1'b0; mem_rdata = 16'h0;
        for (int i = 0; i < 256; i++) mem_model[i] = 16'($urandom);
        mem_model[8'h20] = 16'hBEEF;

        // Power-on reset.
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_dout", data_mem_out, 0);
        chk("rst_err", mem_err, 0);
        chk("rst_wreg", WriteReg_out, 0);
        chk("rst_alu", ALU_res_out, 0);
        chk("rst_stall", stall_n, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        run_instr(1, 0, 0, 0, 1, 16'h1234, 16'h0000, 0, 0);
        run_instr(1, 0, 1, 0, 1, 16'h0040, 16'h0000, 3, 0);
        run_instr(1, 0, 0, 1, 0, 16'h0102, 16'hA5A5, 1, 0);
        run_instr(1, 0, 1, 0, 1, 16'h0041, 16'h0000, 2, 0);
        run_instr(1, 0, 1, 0, 1, 16'h0060, 16'h0000, 0, 0);
        run_instr(1, 0, 1, 0, 1, 16'h0102, 16'h0000, 5, 1);
        run_instr(1, 1, 1, 0, 1, 16'h0044, 16'h0000, 1, 0);
        run_instr(1, 0, 1, 0, 1, 16'h0040, 16'h0000, TO, 0);
        run_instr(1, 0, 1, 0, 1, 16'h0102, 16'h0000, TO + 1, 0);
        run_instr(1, 0, 1, 1, 1, 16'h0040, 16'h5A5A, 2, 0);
        run_instr(1, 0, 1, 0, 1, 16'h0040, 16'h0000, 1, 0);

        // Random instruction mix.
        for (int n = 0; n < 60; n++) begin
            logic [15:0] a;
            a = 16'($urandom);
            a[0] = ($urandom_range(0, 3) == 0);
            run_instr(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), a, 16'($urandom),
                      int'($urandom_range(0, TO + 2)), 1'($urandom_range(0, 1)));
        end

        // Reset while a load is pending.
        valid_in = 1'b1; flush = 1'b0; mem_read_in = 1'b1; mem_write_in = 1'b0;
        WriteReg_in = 1'b1; ALU_res_in = 16'h0080; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_stall", stall_n, 1);
        chk("mid_rst_wreg", WriteReg_out, 0);
        chk("mid_rst_alu", ALU_res_out, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_dout", data_mem_out, 0);
        chk("mid_rst_err", mem_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_dout = 16'h0;
        exp_err_next = 1'b0;
        run_instr(1, 0, 0, 0, 1, 16'h4321, 16'h0000, 0, 0);
        run_instr(1, 0, 1, 0, 1, 16'h0040, 16'h0000, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
